// File: rtl/noc_link_pkg.sv
// Shared constants and types for the router-to-router link.
package noc_link_pkg;

  localparam int unsigned FLIT_W    = 17;
  localparam int unsigned BUF_DEPTH = 5;
  localparam int unsigned TAIL_BIT  = 16;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    IDLE,
    PKT
  } tx_state_t;

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
module credit_counter #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= FULL;
      overflow <= 1'b0;
    end else if (inc && !dec && count == FULL) begin
      // A credit returned while every slot is already free: hold at DEPTH.
      overflow <= 1'b1;
    end else if (dec && !inc && count != '0) begin
      count <= count - ONE;
    end else if (inc && !dec) begin
      count <= count + ONE;
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/link_tx_credit.sv
// Link transmitter: credit-gated flit handshake, registered strobe/data, wormhole framing.
module link_tx_credit
  import noc_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FLIT_W,
  parameter int unsigned DEPTH      = BUF_DEPTH,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] flit_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] link_data_o,
  output logic                  link_send_o,
  input  logic                  credit_i,
  output logic [CNT_W-1:0]      credits_o,
  output logic                  busy_o,
  output logic                  err_o
);

  tx_state_t state_q, state_d;
  logic      accept;
  logic      nonzero;
  logic      tail;

  credit_counter #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_credit (
    .clk      (clk),
    .rst      (rst),
    .dec      (accept),
    .inc      (credit_i),
    .count    (credits_o),
    .nonzero  (nonzero),
    .overflow (err_o)
  );

  assign ready_o = nonzero && !err_o;
  assign accept  = valid_i && ready_o;
  assign tail    = flit_i[DATA_WIDTH-1];
  assign busy_o  = (state_q == PKT);

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = tail ? IDLE : PKT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      link_send_o <= 1'b0;
      link_data_o <= '0;
    end else begin
      state_q     <= state_d;
      link_send_o <= accept;
      if (accept) begin
        link_data_o <= flit_i;
      end
    end
  end

endmodule

// File: tb/tb_link_tx_credit.sv
// Directed plus randomized bench for link_tx_credit against a cycle-level reference model.
module tb_link_tx_credit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] flit_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [16:0] link_data_o;
  logic        link_send_o;
  logic        credit_i = 1'b0;
  logic [2:0]  credits_o;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_cred = 5;
  bit          m_err  = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_send = 1'b0;
  logic [16:0] m_data = '0;

  always #5 clk = ~clk;

  link_tx_credit #(
    .DATA_WIDTH(17),
    .DEPTH(5),
    .CNT_W(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flit_i      (flit_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .link_data_o (link_data_o),
    .link_send_o (link_send_o),
    .credit_i    (credit_i),
    .credits_o   (credits_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check ready before the edge, advance model, check after.
  task automatic step(input bit v, input logic [16:0] f, input bit c, input bit r);
    bit acc;
    @(negedge clk);
    rst = r; valid_i = v; flit_i = f; credit_i = c;
    if (!r) chk("ready", {31'b0, ready_o}, {31'b0, (m_cred != 0 && !m_err)});
    acc = !r && v && m_cred != 0 && !m_err;
    @(posedge clk);
    #1;
    if (r) begin
      m_cred = 5; m_err = 0; m_busy = 0; m_send = 0; m_data = '0;
    end else begin
      m_send = acc;
      if (acc) begin
        m_data = f;
        m_busy = !f[16];
      end
      if (c && !acc && m_cred == 5) m_err = 1'b1;
      else m_cred = m_cred - int'(acc) + int'(c);
    end
    chk("send",    {31'b0, link_send_o}, {31'b0, m_send});
    chk("data",    {15'b0, link_data_o}, {15'b0, m_data});
    chk("credits", {29'b0, credits_o},   m_cred);
    chk("busy",    {31'b0, busy_o},      {31'b0, m_busy});
    chk("err",     {31'b0, err_o},       {31'b0, m_err});
  endtask

  initial begin
    bit          v, c, r;
    logic [16:0] f;

    // reset then idle
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    chk("reset_credits", {29'b0, credits_o}, 32'd5);
    chk("reset_ready",   {31'b0, ready_o},   32'd1);
    for (int i = 0; i < 10; i++) step(0, '0, 0, 0);

    // credit exhaustion: 7 offered, 5 accepted
    for (int i = 1; i <= 7; i++) step(1, 17'(i), 0, 0);
    chk("exhaust_credits", {29'b0, credits_o}, 32'd0);
    chk("exhaust_busy",    {31'b0, busy_o},    32'd1);

    // credit return, then simultaneous accept + credit
    step(1, 17'h00006, 1, 0);
    chk("return_credits", {29'b0, credits_o}, 32'd1);
    step(1, 17'h00006, 1, 0);
    step(1, 17'h00007, 1, 0);
    step(1, 17'h00008, 1, 0);
    chk("simul_credits", {29'b0, credits_o}, 32'd1);

    // refill, then packet framing
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    step(1, 17'h00011, 0, 0);
    chk("head_busy", {31'b0, busy_o}, 32'd1);
    step(1, 17'h00022, 0, 0);
    step(1, 17'h10033, 0, 0);
    chk("tail_busy", {31'b0, busy_o}, 32'd0);
    step(1, 17'h10044, 0, 0);
    chk("single_busy", {31'b0, busy_o}, 32'd0);

    // overflow at full credits
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    chk("ovf_err", {31'b0, err_o}, 32'd1);
    for (int i = 0; i < 3; i++) step(1, 17'h00055, 0, 0);

    // reset mid-packet with a strobe pending and credits = 2
    step(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 17'(17'h00100 + i), 0, 0);
    chk("pre_rst_credits", {29'b0, credits_o}, 32'd2);
    step(1, 17'h00200, 0, 1);
    chk("rst_send",    {31'b0, link_send_o}, 32'd0);
    chk("rst_credits", {29'b0, credits_o},   32'd5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      v = ($urandom % 4) != 0;
      f = 17'($urandom);
      c = (m_cred < 5) ? bit'($urandom % 2) : (($urandom % 24) == 0);
      r = ($urandom % 64) == 0;
      step(v, f, c, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/link_tx_credit.md
Name: link_tx_credit

Overview:
- Transmit side of the router-to-router link; it feeds the downstream router's 5-entry input buffer storage.
- Accepts flits from the local crossbar output with a valid/ready handshake.
- Drives the link with a one-cycle write strobe and registered data.
- Tracks free downstream buffer slots with a credit counter, so the downstream buffer is never written while full.
- Tracks wormhole packet framing so the crossbar can tell whether this output is locked mid-packet.

Parameters:
- DATA_WIDTH, 17: flit width; bit DATA_WIDTH-1 is the tail flag (1 = last flit of the packet).
- DEPTH, 5: downstream buffer depth and reset credit value.
- CNT_W, 3: credit counter width, equal to $clog2(DEPTH+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flit_i  in  DATA_WIDTH  flit from the crossbar.
- valid_i  in  1  flit_i is valid this cycle.
- ready_o  out  1  the block can accept flit_i this cycle.
- link_data_o  out  DATA_WIDTH  flit to the downstream buffer's data input.
- link_send_o  out  1  one-cycle write strobe to the downstream buffer's receive input.
- credit_i  in  1  downstream buffer released one entry (its send pulse).
- credits_o  out  CNT_W  current free downstream slots.
- busy_o  out  1  a packet is in progress (head sent, tail not yet sent).
- err_o  out  1  sticky credit-overflow error flag.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state updates on the rising clk edge.
- Reset values:
  - credits = DEPTH (5).
  - link_send_o = 0, link_data_o = 0.
  - state = IDLE, busy_o = 0, err_o = 0.
- Reset asserted mid-packet or mid-transfer discards the packet state and any in-flight strobe. The next cycle shows reset values.
- ready_o = (credits != 0) and not err_o. It is combinational from registered state only; it does not depend on valid_i or credit_i.
- Accept: a flit is accepted when valid_i and ready_o are both 1 at a clock edge.
- Latency: a flit accepted at edge N appears on link_data_o with link_send_o = 1 for exactly the cycle after edge N.
  - With no accept at an edge, link_send_o = 0 after that edge.
  - link_data_o holds its last value.
- Back-to-back accepts produce back-to-back strobes at full rate, one flit per cycle.
- Credit update each edge: credits_next = credits - accept + credit_i.
  - Accept and credit_i together: credits unchanged.
  - credits == 0 and credit_i = 1: no accept is possible (ready_o = 0); credits become 1, and ready_o = 1 the next cycle.
  - credits == DEPTH, credit_i = 1, no accept: overflow. credits stay saturated at DEPTH, and err_o sets and stays set until rst.
  - Underflow cannot occur because accept is gated by ready_o.
- Packet FSM, states IDLE and PKT:
  - IDLE, accept with tail = 0 -> PKT.
  - IDLE, accept with tail = 1 (single-flit packet) -> IDLE.
  - PKT, accept with tail = 0 -> PKT.
  - PKT, accept with tail = 1 -> IDLE.
  - No accept -> state holds.
- busy_o = (state == PKT). It is registered and updates at the accepting edge.
- valid_i without ready_o is a stall. The block does not capture flit_i; the sender must hold the flit.
- credits_o reflects the registered count.

Decomposition:
- Package noc_link_pkg holds:
  - FLIT_W = 17, BUF_DEPTH = 5, TAIL_BIT = 16.
  - typedef flit_t (logic [FLIT_W-1:0]).
  - enum tx_state_t {IDLE, PKT}.
- One sub-module, credit_counter:
  - Parameters DEPTH and CNT_W.
  - Inputs: clk, rst, dec, inc.
  - Outputs: count, nonzero, overflow.
  - Contains the saturating up/down counter and the sticky overflow flag.
- The top level holds the FSM, the output data/strobe registers and the ready logic.

Test Plan:
- Reset then idle:
  - Required after reset: credits_o = 5, ready_o = 1, link_send_o = 0, busy_o = 0, err_o = 0.
  - Hold for 10 cycles with valid_i = 0: all outputs unchanged.
- Credit exhaustion:
  - Stimulus: valid_i = 1 for 7 cycles with flits 0x00001..0x00007, tail = 0, credit_i = 0.
  - Required: exactly 5 strobes carrying 0x00001..0x00005 on consecutive cycles; credits_o steps 4,3,2,1,0; ready_o = 0 from the 6th cycle; busy_o = 1.
- Credit return and simultaneous events:
  - Stimulus: from credits = 0, pulse credit_i once; then keep valid_i = 1 and credit_i = 1 together for 3 cycles.
  - Required: credits_o goes 0 -> 1, then stays 1 during the simultaneous cycles; one strobe per cycle of 0x00006, then further flits in order.
- Packet framing:
  - Stimulus: head 0x00011, body 0x00022, tail 0x10033, then single-flit packet 0x10044.
  - Required: busy_o = 1 after the head, 0 after the edge accepting 0x10033, and stays 0 through 0x10044.
- Overflow:
  - Stimulus: at credits = 5, assert credit_i for one cycle with no accept.
  - Required: credits_o stays 5, err_o = 1 sticky, ready_o = 0 until rst.
- Reset mid-packet:
  - Stimulus: assert rst in the cycle a strobe is pending, with state = PKT and credits = 2.
  - Required next cycle: link_send_o = 0, busy_o = 0, credits_o = 5, err_o = 0.
